fetch_buffer: RTL and testbench

Instruction fetch buffer between the program counter / instruction ROM and decode. Each cycle it captures the 9-bit instruction read at the current PC, together with that PC, into a small FIFO. It presents the oldest entry to decode with a valid/ready handshake. Its `full_o` drives the program counter's `Halt`, and a taken jump flushes wrong-path entries.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_buf_ptr.sv | 24 ++
 rtl/fetch_buffer.sv | 98 +++++++++
 tb/tb_fetch_buffer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths and entry type for the instruction fetch buffer.
package fetch_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 9;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buf_ptr.sv
// Circular-buffer pointer with an extra wrap bit; clr has priority over inc.
module fetch_buf_ptr #(
   parameter int AW = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        inc,
   input  logic        clr,
   output logic [AW:0] ptr
);

   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + ONE;
      end
   end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch FIFO between PC/ROM and decode; full_o feeds PC Halt.
// Optional FETCH_BUF_BYPASS_EN: empty-buffer pass-through with zero latency.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int PC_W    = fetch_pkg::PC_W,
   parameter int INSTR_W = fetch_pkg::INSTR_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     fetch_valid,
   input  logic [PC_W-1:0]          pc_i,
   input  logic [INSTR_W-1:0]       instr_i,
   input  logic                     flush,
   input  logic                     deq_ready,
   output logic                     valid_o,
   output logic [PC_W-1:0]          pc_o,
   output logic [INSTR_W-1:0]       instr_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW:0]   rd_ptr;
   logic [AW:0]   wr_ptr;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;
   logic          empty;
   logic          full;
   logic          bypass;
   logic          enq;
   logic          deq;

   assign rd_idx = rd_ptr[AW-1:0];
   assign wr_idx = wr_ptr[AW-1:0];

   // Flags come from pointer registers only, so Halt has no path from inputs.
   assign empty = (rd_ptr == wr_ptr);
   assign full  = (rd_idx == wr_idx) && (rd_ptr[AW] != wr_ptr[AW]);

`ifdef FETCH_BUF_BYPASS_EN
   assign bypass = empty & fetch_valid & ~flush & deq_ready;
`else
   assign bypass = 1'b0;
`endif

   assign enq = fetch_valid & ~full & ~flush & ~bypass;
   assign deq = ~empty & deq_ready & ~flush;

   fetch_buf_ptr #(.AW(AW)) u_rd_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (deq),
      .clr     (flush),
      .ptr     (rd_ptr)
   );

   fetch_buf_ptr #(.AW(AW)) u_wr_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (enq),
      .clr     (flush),
      .ptr     (wr_ptr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (enq) begin
         mem[wr_idx] <= '{pc: pc_i, instr: instr_i};
      end
   end

   always_comb begin
      valid_o = ~empty;
      pc_o    = mem[rd_idx].pc;
      instr_o = mem[rd_idx].instr;
      if (bypass) begin
         valid_o = 1'b1;
         pc_o    = pc_i;
         instr_o = instr_i;
      end
   end

   assign full_o  = full;
   assign count_o = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed, table-driven bench for fetch_buffer (DEPTH=2).
module tb_fetch_buffer;
   import fetch_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         fetch_valid;
   logic [7:0]   pc_i;
   logic [8:0]   instr_i;
   logic         flush;
   logic         deq_ready;
   logic         valid_o;
   logic [7:0]   pc_o;
   logic [8:0]   instr_o;
   logic         full_o;
   logic [1:0]   count_o;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic       fv;
      logic [7:0] pc;
      logic       fl;
      logic       dr;
      logic       ev;
      logic [7:0] epc;
      logic       ef;
      int         ec;
   } vec_t;

   vec_t vecs[$];

   fetch_buffer #(.DEPTH(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch_valid (fetch_valid),
      .pc_i        (pc_i),
      .instr_i     (instr_i),
      .flush       (flush),
      .deq_ready   (deq_ready),
      .valid_o     (valid_o),
      .pc_o        (pc_o),
      .instr_o     (instr_o),
      .full_o      (full_o),
      .count_o     (count_o)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] instr_of(input logic [7:0] pc);
      return {1'b1, pc} ^ 9'h0B3;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic add(input logic fv, input int pc, input logic fl, input logic dr,
                      input logic ev, input int epc, input logic ef, input int ec);
      vec_t v;
      v.fv = fv; v.pc = 8'(pc); v.fl = fl; v.dr = dr;
      v.ev = ev; v.epc = 8'(epc); v.ef = ef; v.ec = ec;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic fv, input logic [7:0] pc, input logic fl, input logic dr);
      fetch_valid = fv;
      pc_i        = pc;
      instr_i     = instr_of(pc);
      flush       = fl;
      deq_ready   = dr;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      #1;
      check("reset valid", valid_o, 0);
      check("reset full",  full_o,  0);
      check("reset count", count_o, 0);
      check("reset pc",    pc_o,    0);
      check("reset instr", instr_o, 0);
      @(negedge clk);
      reset_n = 1'b1;

`ifndef FETCH_BUF_BYPASS_EN
      // fv pc fl dr | valid pc full count  (outputs seen before that cycle's edge)
      // streaming 0..5
      add(1, 0,0,1, 0, 0,0,0); add(1, 1,0,1, 1, 0,0,1); add(1, 2,0,1, 1, 1,0,1);
      add(1, 3,0,1, 1, 2,0,1); add(1, 4,0,1, 1, 3,0,1); add(1, 5,0,1, 1, 4,0,1);
      add(0, 0,0,1, 1, 5,0,1); add(0, 0,0,0, 0, 0,0,0);
      // back-pressure from PC 10, PC held at 12 while full
      add(1,10,0,0, 0, 0,0,0); add(1,11,0,0, 1,10,0,1); add(1,12,0,0, 1,10,1,2);
      add(1,12,0,0, 1,10,1,2); add(1,12,0,1, 1,10,1,2); add(1,12,0,1, 1,11,0,1);
      add(1,13,0,1, 1,12,0,1); add(0, 0,0,1, 1,13,0,1); add(0, 0,0,0, 0, 0,0,0);
      // flush with two entries buffered, then target 67
      add(1,20,0,0, 0, 0,0,0); add(1,21,0,0, 1,20,0,1); add(1,22,1,1, 1,20,1,2);
      add(1,67,0,0, 0, 0,0,0); add(0, 0,0,1, 1,67,0,1); add(0, 0,0,0, 0, 0,0,0);
      // flush with one entry and deq_ready high
      add(1,30,0,0, 0, 0,0,0); add(1,31,1,1, 1,30,0,1); add(0, 0,0,0, 0, 0,0,0);
      // wrap-around: 7 enqueue/dequeue pairs with stalls
      add(1,40,0,0, 0, 0,0,0); add(1,41,0,1, 1,40,0,1); add(0, 0,0,0, 1,41,0,1);
      add(1,42,0,0, 1,41,0,1); add(1,43,0,1, 1,41,1,2); add(1,43,0,1, 1,42,0,1);
      add(1,44,0,1, 1,43,0,1); add(1,45,0,0, 1,44,0,1); add(1,46,0,1, 1,44,1,2);
      add(1,46,0,1, 1,45,0,1); add(0, 0,0,0, 1,46,0,1); add(0, 0,0,1, 1,46,0,1);
      add(0, 0,0,0, 0, 0,0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].fv, vecs[i].pc, vecs[i].fl, vecs[i].dr);
         #1;
         check($sformatf("vec%0d valid", i), valid_o, vecs[i].ev);
         check($sformatf("vec%0d full", i),  full_o,  vecs[i].ef);
         check($sformatf("vec%0d count", i), count_o, vecs[i].ec);
         if (vecs[i].ev) begin
            check($sformatf("vec%0d pc", i),    pc_o,    vecs[i].epc);
            check($sformatf("vec%0d instr", i), instr_o, instr_of(vecs[i].epc));
         end
      end
`else
      @(negedge clk);
      drive(1'b1, 8'd121, 1'b0, 1'b1);
      #1;
      check("bypass valid", valid_o, 1);
      check("bypass pc",    pc_o,    121);
      check("bypass instr", instr_o, instr_of(8'd121));
      check("bypass count", count_o, 0);
      check("bypass full",  full_o,  0);
      @(negedge clk);
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      #1;
      check("bypass no write valid", valid_o, 0);
      check("bypass no write count", count_o, 0);
`endif

      // asynchronous reset with two entries held
      @(negedge clk);
      drive(1'b1, 8'd80, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 8'd81, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      #1;
      check("pre-reset count", count_o, 2);
      check("pre-reset full",  full_o,  1);
      check("pre-reset pc",    pc_o,    80);
      reset_n = 1'b0;
      #1;
      check("async reset valid", valid_o, 0);
      check("async reset count", count_o, 0);
      check("async reset full",  full_o,  0);
      check("async reset pc",    pc_o,    0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post-reset valid", valid_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
